// File: rtl/decode.sv
// -----------------------------------------------------------------------------
// decode : second stage of the 5-stage MIPS-subset pipeline.
//
// Decodes the instruction held in IF/ID, reads the 32x32 register file (written
// back from WB), resolves branches/jumps in this stage (one delay slot), detects
// load-use and branch-operand hazards and loads the ID/EX pipeline register.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   if_id_instruc/nextpc    instruction word and its PC+1 from fetch
//   wb_id_*                 writeback register write port
//   mem_id_*                MEM-stage result, forwarded to branch/jr operands
//   id_if_*                 combinational redirect / stall information to fetch
//   id_ex_*                 registered operands and control for execute
// -----------------------------------------------------------------------------
module decode (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_id_instruc,
    input  logic [31:0] if_id_nextpc,
    input  logic        wb_id_regwrite,
    input  logic [4:0]  wb_id_regdest,
    input  logic [31:0] wb_id_writedata,
    input  logic        mem_id_regwrite,
    input  logic [4:0]  mem_id_regdest,
    input  logic [31:0] mem_id_data,
    output logic        id_if_selpcsource,
    output logic [1:0]  id_if_selpctype,
    output logic [31:0] id_if_pcimd2ext,
    output logic [31:0] id_if_pcindex,
    output logic [31:0] id_if_rega,
    output logic        id_if_stall,
    output logic [31:0] id_ex_rega,
    output logic [31:0] id_ex_regb,
    output logic [31:0] id_ex_imedext,
    output logic [4:0]  id_ex_rs,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_regdest,
    output logic [2:0]  id_ex_aluop,
    output logic        id_ex_alusrc,
    output logic        id_ex_regwrite,
    output logic        id_ex_memread,
    output logic        id_ex_memwrite,
    output logic        id_ex_memtoreg
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_PASSA = 3'b101;

    // Register r matches an enabled write port; r0 never matches.
    function automatic logic port_hit(input logic [4:0] r, input logic we, input logic [4:0] dest);
        return we && (dest == r) && (r != 5'd0);
    endfunction

    logic [31:0] regs_r [32];

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [31:0] imm_ext_s;

    logic        is_nop_s, is_ralu_s, is_jr_s, is_addi_s, is_lw_s, is_sw_s;
    logic        is_beq_s, is_bne_s, is_j_s, is_jal_s, is_illegal_s;
    logic [2:0]  alu_op_s;

    logic [31:0] rs_val_s, rt_val_s, br_a_s, br_b_s;
    logic        rt_src_s, load_use_s, br_haz_s, stall_s, taken_s, bubble_s;
    logic [1:0]  pctype_s;

    logic [31:0] id_ex_rega_r, id_ex_regb_r, id_ex_imedext_r;
    logic [4:0]  id_ex_rs_r, id_ex_rt_r, id_ex_regdest_r;
    logic [2:0]  id_ex_aluop_r;
    logic        id_ex_alusrc_r, id_ex_regwrite_r, id_ex_memread_r;
    logic        id_ex_memwrite_r, id_ex_memtoreg_r;

    assign op_s      = if_id_instruc[31:26];
    assign funct_s   = if_id_instruc[5:0];
    assign rs_s      = if_id_instruc[25:21];
    assign rt_s      = if_id_instruc[20:16];
    assign rd_s      = if_id_instruc[15:11];
    assign imm_ext_s = {{16{if_id_instruc[15]}}, if_id_instruc[15:0]};

    // Instruction class decode; the all-zero word is a NOP, not an illegal R-type.
    always_comb begin
        is_nop_s     = 1'b0;
        is_ralu_s    = 1'b0;
        is_jr_s      = 1'b0;
        is_addi_s    = 1'b0;
        is_lw_s      = 1'b0;
        is_sw_s      = 1'b0;
        is_beq_s     = 1'b0;
        is_bne_s     = 1'b0;
        is_j_s       = 1'b0;
        is_jal_s     = 1'b0;
        is_illegal_s = 1'b0;
        alu_op_s     = ALU_ADD;
        if (if_id_instruc == 32'd0) begin
            is_nop_s = 1'b1;
        end else begin
            case (op_s)
                OP_RTYPE: begin
                    case (funct_s)
                        FN_ADD:  begin is_ralu_s = 1'b1; alu_op_s = ALU_ADD; end
                        FN_SUB:  begin is_ralu_s = 1'b1; alu_op_s = ALU_SUB; end
                        FN_AND:  begin is_ralu_s = 1'b1; alu_op_s = ALU_AND; end
                        FN_OR:   begin is_ralu_s = 1'b1; alu_op_s = ALU_OR;  end
                        FN_SLT:  begin is_ralu_s = 1'b1; alu_op_s = ALU_SLT; end
                        FN_JR:   is_jr_s = 1'b1;
                        default: is_illegal_s = 1'b1;
                    endcase
                end
                OP_ADDI: is_addi_s = 1'b1;
                OP_LW:   is_lw_s   = 1'b1;
                OP_SW:   is_sw_s   = 1'b1;
                OP_BEQ:  is_beq_s  = 1'b1;
                OP_BNE:  is_bne_s  = 1'b1;
                OP_J:    is_j_s    = 1'b1;
                OP_JAL:  begin is_jal_s = 1'b1; alu_op_s = ALU_PASSA; end
                default: is_illegal_s = 1'b1;
            endcase
        end
    end

    // Operand read: WB bypass over the array; branch/jr operands additionally prefer MEM.
    always_comb begin
        if (rs_s == 5'd0) begin
            rs_val_s = 32'd0;
        end else if (port_hit(rs_s, wb_id_regwrite, wb_id_regdest)) begin
            rs_val_s = wb_id_writedata;
        end else begin
            rs_val_s = regs_r[rs_s];
        end
        if (rt_s == 5'd0) begin
            rt_val_s = 32'd0;
        end else if (port_hit(rt_s, wb_id_regwrite, wb_id_regdest)) begin
            rt_val_s = wb_id_writedata;
        end else begin
            rt_val_s = regs_r[rt_s];
        end
        if (port_hit(rs_s, mem_id_regwrite, mem_id_regdest)) begin
            br_a_s = mem_id_data;
        end else begin
            br_a_s = rs_val_s;
        end
        if (port_hit(rt_s, mem_id_regwrite, mem_id_regdest)) begin
            br_b_s = mem_id_data;
        end else begin
            br_b_s = rt_val_s;
        end
    end

    // Hazard detection and redirect resolution.
    always_comb begin
        rt_src_s   = is_ralu_s | is_jr_s | is_sw_s | is_beq_s | is_bne_s;
        load_use_s = id_ex_memread_r && (id_ex_regdest_r != 5'd0) &&
                     ((id_ex_regdest_r == rs_s) || (rt_src_s && (id_ex_regdest_r == rt_s)));
        // EX result is not forwardable to ID yet, so a branch/jr reading it must wait.
        br_haz_s   = id_ex_regwrite_r && (id_ex_regdest_r != 5'd0) &&
                     (((is_beq_s || is_bne_s) && ((id_ex_regdest_r == rs_s) || (id_ex_regdest_r == rt_s))) ||
                      (is_jr_s && (id_ex_regdest_r == rs_s)));
        stall_s    = load_use_s | br_haz_s;
        taken_s    = (is_beq_s && (br_a_s == br_b_s)) || (is_bne_s && (br_a_s != br_b_s)) ||
                     is_j_s || is_jal_s || is_jr_s || is_illegal_s;
        if (is_illegal_s) begin
            pctype_s = 2'b11;
        end else if (is_j_s || is_jal_s) begin
            pctype_s = 2'b10;
        end else if (is_jr_s) begin
            pctype_s = 2'b01;
        end else begin
            pctype_s = 2'b00;
        end
        bubble_s   = stall_s | is_illegal_s | is_nop_s;
    end

    assign id_if_selpcsource = taken_s && !stall_s;
    assign id_if_selpctype   = pctype_s;
    assign id_if_pcimd2ext   = if_id_nextpc + imm_ext_s;
    assign id_if_pcindex     = {if_id_nextpc[31:26], if_id_instruc[25:0]};
    assign id_if_rega        = br_a_s;
    assign id_if_stall       = stall_s;

    // Register file write port; r0 is never written so it always reads zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wb_id_regwrite && (wb_id_regdest != 5'd0)) begin
            regs_r[wb_id_regdest] <= wb_id_writedata;
        end
    end

    // ID/EX pipeline register; stalls, illegal opcodes and NOPs load an all-zero bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset || bubble_s) begin
            id_ex_rega_r     <= 32'd0;
            id_ex_regb_r     <= 32'd0;
            id_ex_imedext_r  <= 32'd0;
            id_ex_rs_r       <= 5'd0;
            id_ex_rt_r       <= 5'd0;
            id_ex_regdest_r  <= 5'd0;
            id_ex_aluop_r    <= 3'b000;
            id_ex_alusrc_r   <= 1'b0;
            id_ex_regwrite_r <= 1'b0;
            id_ex_memread_r  <= 1'b0;
            id_ex_memwrite_r <= 1'b0;
            id_ex_memtoreg_r <= 1'b0;
        end else begin
            // jal carries its link value through the ALU as passA.
            id_ex_rega_r     <= is_jal_s ? (if_id_nextpc + 32'd1) : rs_val_s;
            id_ex_regb_r     <= rt_val_s;
            id_ex_imedext_r  <= imm_ext_s;
            // j/jal have no register fields; zero them so EX forwarding never matches.
            id_ex_rs_r       <= (is_j_s || is_jal_s) ? 5'd0 : rs_s;
            id_ex_rt_r       <= (is_j_s || is_jal_s) ? 5'd0 : rt_s;
            id_ex_regdest_r  <= is_ralu_s ? rd_s :
                                (is_addi_s || is_lw_s) ? rt_s :
                                is_jal_s ? 5'd31 : 5'd0;
            id_ex_aluop_r    <= alu_op_s;
            id_ex_alusrc_r   <= is_addi_s | is_lw_s | is_sw_s;
            id_ex_regwrite_r <= is_ralu_s | is_addi_s | is_lw_s | is_jal_s;
            id_ex_memread_r  <= is_lw_s;
            id_ex_memwrite_r <= is_sw_s;
            id_ex_memtoreg_r <= is_lw_s;
        end
    end

    assign id_ex_rega     = id_ex_rega_r;
    assign id_ex_regb     = id_ex_regb_r;
    assign id_ex_imedext  = id_ex_imedext_r;
    assign id_ex_rs       = id_ex_rs_r;
    assign id_ex_rt       = id_ex_rt_r;
    assign id_ex_regdest  = id_ex_regdest_r;
    assign id_ex_aluop    = id_ex_aluop_r;
    assign id_ex_alusrc   = id_ex_alusrc_r;
    assign id_ex_regwrite = id_ex_regwrite_r;
    assign id_ex_memread  = id_ex_memread_r;
    assign id_ex_memwrite = id_ex_memwrite_r;
    assign id_ex_memtoreg = id_ex_memtoreg_r;

endmodule
